// File: rtl/ov7670_luma_capture_if.sv
// Bus bundle between the OV7670 camera side and the luma capture stage.
// The capture stage (slave) receives the camera byte stream and controls,
// and drives the frame-RAM write port plus frame status.
interface ov7670_luma_capture_if #(
  parameter int ADDR_W = 19
);
  logic              vsync;
  logic              href;
  logic [7:0]        din;
  logic              decimate;
  logic              pause;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        dout;
  logic              we;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic              line_err;

  modport master (
    output vsync, href, din, decimate, pause,
    input  addr, dout, we, frame_done, frame_cnt, line_err
  );

  modport slave (
    input  vsync, href, din, decimate, pause,
    output addr, dout, we, frame_done, frame_cnt, line_err
  );
endinterface

// File: rtl/ov7670_luma_capture.sv
// OV7670 luma capture: frames the YUV422 byte stream with VSYNC/HREF, keeps
// the Y byte of every pixel and writes it to linear RAM addresses, with
// optional 2x2 decimation, frame completion pulse, frame counter and a
// sticky line-length error flag.
module ov7670_luma_capture #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int ADDR_W  = 19,
  parameter int Y_FIRST = 1
) (
  input  logic                   pclk,
  input  logic                   rst,
  ov7670_luma_capture_if.slave   bus
);

  // x counts one past WIDTH so that over-long lines are still detected.
  localparam int XW = $clog2(WIDTH + 2);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam logic [XW-1:0]     X_END    = XW'(WIDTH);
  localparam logic [XW-1:0]     X_SAT    = XW'(WIDTH + 1);
  localparam logic [YW-1:0]     Y_END    = YW'(HEIGHT);
  localparam logic [ADDR_W:0]   LIM_FULL = (ADDR_W + 1)'(WIDTH * HEIGHT);
  localparam logic [ADDR_W:0]   LIM_DEC  = (ADDR_W + 1)'(WIDTH * HEIGHT / 4);
  // Byte phase that carries Y within a pixel pair.
  localparam logic              Y_PH     = (Y_FIRST != 0) ? 1'b0 : 1'b1;

  typedef enum logic [1:0] {
    S_SYNC,
    S_VBLANK,
    S_ACTIVE
  } state_t;

  state_t            state_reg;
  logic              href_d_reg;
  logic              vsync_d_reg;
  logic              ph_reg;
  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              dec_l_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        dout_reg;
  logic              we_reg;
  logic              frame_done_reg;
  logic [7:0]        frame_cnt_reg;
  logic              line_err_reg;

  logic              href_rise;
  logic              href_fall;
  logic              vs_rise;
  logic              vs_fall;
  logic              ph_cur;
  logic [XW-1:0]     x_cur;
  logic              y_byte;
  logic [ADDR_W:0]   limit;
  logic              wr_ok;

  // Edge detection, effective byte phase / pixel index and the write decision.
  always_comb begin
    href_rise = bus.href & ~href_d_reg;
    href_fall = ~bus.href & href_d_reg;
    vs_rise   = bus.vsync & ~vsync_d_reg;
    vs_fall   = ~bus.vsync & vsync_d_reg;
    // The first byte of a line is always phase 0 at pixel 0.
    ph_cur    = href_rise ? 1'b0 : ph_reg;
    x_cur     = href_rise ? '0 : x_reg;
    y_byte    = bus.href && (ph_cur == Y_PH);
    limit     = dec_l_reg ? LIM_DEC : LIM_FULL;
    wr_ok     = y_byte
              && (x_cur < X_END)
              && (y_reg < Y_END)
              && (!dec_l_reg || (!x_cur[0] && !y_reg[0]))
              && ({1'b0, wr_ptr_reg} < limit);
  end

  // Frame FSM, pixel/line counters and registered RAM write port.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg      <= S_SYNC;
      href_d_reg     <= 1'b0;
      vsync_d_reg    <= 1'b0;
      ph_reg         <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      wr_ptr_reg     <= '0;
      dec_l_reg      <= 1'b0;
      addr_reg       <= '0;
      dout_reg       <= '0;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      line_err_reg   <= 1'b0;
    end else begin
      href_d_reg     <= bus.href;
      vsync_d_reg    <= bus.vsync;
      we_reg         <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        S_SYNC: begin
          // Any partial frame is dropped until the next vertical blank.
          if (bus.vsync) state_reg <= S_VBLANK;
        end
        S_VBLANK: begin
          if (vs_fall) begin
            if (bus.pause) begin
              state_reg <= S_SYNC;
            end else begin
              dec_l_reg    <= bus.decimate;
              x_reg        <= '0;
              y_reg        <= '0;
              ph_reg       <= 1'b0;
              wr_ptr_reg   <= '0;
              line_err_reg <= 1'b0;
              state_reg    <= S_ACTIVE;
            end
          end
        end
        S_ACTIVE: begin
          if (bus.href) begin
            ph_reg <= ~ph_cur;
            if (ph_cur) x_reg <= (x_cur == X_SAT) ? x_cur : x_cur + XW'(1);
            else        x_reg <= x_cur;
            // A line beyond the last row is an error and never writes.
            if (href_rise && (y_reg == Y_END)) line_err_reg <= 1'b1;
            if (wr_ok) begin
              addr_reg   <= wr_ptr_reg;
              dout_reg   <= bus.din;
              we_reg     <= 1'b1;
              wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
          end
          if (href_fall) begin
            if ((x_reg != X_END) || ph_reg) line_err_reg <= 1'b1;
            if (y_reg != Y_END) y_reg <= y_reg + YW'(1);
          end
          if (vs_rise) begin
            frame_done_reg <= 1'b1;
            frame_cnt_reg  <= frame_cnt_reg + 8'd1;
            state_reg      <= S_VBLANK;
            // Frame cut while a line is still in progress.
            if (bus.href) line_err_reg <= 1'b1;
          end
        end
        default: state_reg <= S_SYNC;
      endcase
    end
  end

  assign bus.addr       = addr_reg;
  assign bus.dout       = dout_reg;
  assign bus.we         = we_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.frame_cnt  = frame_cnt_reg;
  assign bus.line_err   = line_err_reg;

endmodule

// File: tb/tb_ov7670_luma_capture.sv
// Bench for ov7670_luma_capture: a YUYV build (index 0) and a UYVY build
// (index 1) share one camera stream. A pixel/line-level model predicts every
// RAM write (address, data, cycle); a vector table adds hand-computed frame
// totals, and short sequences cover reset mid-frame and counter wrap.
module tb_ov7670_luma_capture;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int AW   = 6;
  localparam int FULL = W * H;
  localparam int DECN = W * H / 4;
  localparam int NV   = 11;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    bit    pause;
    bit    dec;
    int    nlines;
    int    short_line;
    bit    cut;
    int    exp_writes;
    int    exp_last;
    bit    exp_err;
    int    exp_done;
    string name;
  } vec_t;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       href;
  logic [7:0] din;
  logic       decimate;
  logic       pause;

  logic [AW-1:0] o_addr [2];
  logic [7:0]    o_dout [2];
  logic [7:0]    o_cnt  [2];
  logic [1:0]    o_we;
  logic [1:0]    o_done;
  logic [1:0]    o_err;

  wr_t exp_q [2][$];
  wr_t act_q [2][$];
  int  done_cnt [2] = '{0, 0};
  int  cyc = 0;

  int  n_checks = 0;
  int  n_fail   = 0;

  // Model state
  bit  cap = 1'b0;
  bit  dec_m = 1'b0;
  int  line_idx = 0;
  int  wcnt [2] = '{0, 0};
  int  exp_cnt = 0;
  bit  exp_err = 1'b0;
  int  exp_done = 0;

  // Per-frame snapshots
  int  a_base [2] = '{0, 0};
  int  e_base [2] = '{0, 0};
  int  d_base [2] = '{0, 0};
  int  exp_done_base = 0;

  vec_t vecs [NV];

  ov7670_luma_capture_if #(.ADDR_W(AW)) bus [2] ();

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wr_t mon_w;

    assign bus[gi].vsync    = vsync;
    assign bus[gi].href     = href;
    assign bus[gi].din      = din;
    assign bus[gi].decimate = decimate;
    assign bus[gi].pause    = pause;

    assign o_addr[gi] = bus[gi].addr;
    assign o_dout[gi] = bus[gi].dout;
    assign o_cnt[gi]  = bus[gi].frame_cnt;
    assign o_we[gi]   = bus[gi].we;
    assign o_done[gi] = bus[gi].frame_done;
    assign o_err[gi]  = bus[gi].line_err;

    ov7670_luma_capture #(
      .WIDTH  (W),
      .HEIGHT (H),
      .ADDR_W (AW),
      .Y_FIRST((gi == 0) ? 1 : 0)
    ) dut (
      .pclk(pclk),
      .rst (rst),
      .bus (bus[gi])
    );

    // Record every RAM write and frame_done pulse, away from the active edge.
    always @(negedge pclk) begin
      if (bus[gi].we === 1'b1) begin
        mon_w.addr = int'(bus[gi].addr);
        mon_w.data = int'(bus[gi].dout);
        mon_w.cyc  = cyc;
        act_q[gi].push_back(mon_w);
      end
      if (bus[gi].frame_done === 1'b1) done_cnt[gi] = done_cnt[gi] + 1;
    end
  end

  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    for (int g = 0; g < 2; g++) begin
      a_base[g] = act_q[g].size();
      e_base[g] = exp_q[g].size();
      d_base[g] = done_cnt[g];
    end
    exp_done_base = exp_done;
  endtask

  task automatic chk_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s dut%0d addr", tag, g), int'(o_addr[g]), 0);
      chk($sformatf("%s dut%0d dout", tag, g), int'(o_dout[g]), 0);
      chk($sformatf("%s dut%0d we", tag, g), int'(o_we[g]), 0);
      chk($sformatf("%s dut%0d frame_done", tag, g), int'(o_done[g]), 0);
      chk($sformatf("%s dut%0d frame_cnt", tag, g), int'(o_cnt[g]), 0);
      chk($sformatf("%s dut%0d line_err", tag, g), int'(o_err[g]), 0);
    end
  endtask

  // Model: a byte at index b of the current line. Pixel p = b/2; Y sits in
  // byte 0 (YUYV) or byte 1 (UYVY) of the pair; written while inside the
  // frame, on the decimation grid and below the write limit.
  task automatic model_byte(input int b, input logic [7:0] v);
    int  p;
    int  ypos;
    int  lim;
    wr_t w;
    p = b / 2;
    if (!cap) return;
    for (int g = 0; g < 2; g++) begin
      ypos = (g == 0) ? 0 : 1;
      lim  = dec_m ? DECN : FULL;
      if ((b % 2 == ypos) && (p < W) && (line_idx < H) &&
          (!dec_m || ((p % 2 == 0) && (line_idx % 2 == 0))) && (wcnt[g] < lim)) begin
        w.addr = wcnt[g];
        w.data = int'(v);
        w.cyc  = cyc + 1;
        exp_q[g].push_back(w);
        wcnt[g]++;
      end
    end
  endtask

  task automatic model_vs_rise(input bit href_hi);
    if (cap) begin
      exp_done++;
      exp_cnt = (exp_cnt + 1) % 256;
      if (href_hi) exp_err = 1'b1;
      cap = 1'b0;
    end
  endtask

  task automatic start_frame(input bit p, input bit d);
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) tick();
    snap();
    pause    = p;
    decimate = d;
    vsync    = 1'b0;
    if (!p) begin
      cap      = 1'b1;
      dec_m    = d;
      line_idx = 0;
      wcnt[0]  = 0;
      wcnt[1]  = 0;
      exp_err  = 1'b0;
    end
    tick();
    // Controls are frame-start samples only; flip them mid-frame.
    pause    = ~p;
    decimate = ~d;
    for (int g = 0; g < 2; g++)
      chk($sformatf("frame start dut%0d line_err", g), int'(o_err[g]), int'(exp_err));
    repeat (2) tick();
  endtask

  // Drive one HREF line of nb random bytes; vsync rises with byte cut_at.
  task automatic drive_line(input int nb, input int cut_at);
    logic [7:0] v;
    if (cap && (line_idx >= H)) exp_err = 1'b1;
    for (int b = 0; b < nb; b++) begin
      v    = 8'($urandom);
      href = 1'b1;
      din  = v;
      model_byte(b, v);
      if (b == cut_at) begin
        vsync = 1'b1;
        model_vs_rise(1'b1);
      end
      tick();
    end
    href = 1'b0;
    din  = 8'($urandom);
    if (cap) begin
      if (nb != 2 * W) exp_err = 1'b1;
      line_idx++;
    end
    repeat (3) tick();
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    model_vs_rise(href);
    repeat (3) tick();
  endtask

  task automatic run_frame(input bit p, input bit d, input int nlines,
                           input int short_line, input bit cut);
    start_frame(p, d);
    for (int l = 0; l < nlines; l++) begin
      if (cut && (l == nlines - 1)) drive_line(2 * W, 3);
      else drive_line((l == short_line) ? 2 * W - 2 : 2 * W, -1);
    end
    if (!cut) end_frame();
  endtask

  // Compare recorded writes and frame status with the model.
  task automatic check_frame(input string tag);
    int  na;
    int  ne;
    wr_t a;
    wr_t e;
    for (int g = 0; g < 2; g++) begin
      na = act_q[g].size() - a_base[g];
      ne = exp_q[g].size() - e_base[g];
      chk($sformatf("%s dut%0d write count", tag, g), na, ne);
      for (int i = 0; (i < na) && (i < ne); i++) begin
        a = act_q[g][a_base[g] + i];
        e = exp_q[g][e_base[g] + i];
        chk($sformatf("%s dut%0d wr%0d addr", tag, g, i), a.addr, e.addr);
        chk($sformatf("%s dut%0d wr%0d data", tag, g, i), a.data, e.data);
        chk($sformatf("%s dut%0d wr%0d cycle", tag, g, i), a.cyc, e.cyc);
      end
      chk($sformatf("%s dut%0d frame_done pulses", tag, g), done_cnt[g] - d_base[g],
          exp_done - exp_done_base);
      chk($sformatf("%s dut%0d frame_cnt", tag, g), int'(o_cnt[g]), exp_cnt);
      chk($sformatf("%s dut%0d line_err", tag, g), int'(o_err[g]), int'(exp_err));
    end
  endtask

  initial begin
    int na;
    int last;
    int nl;
    int nb;

    // pause, dec, lines, short line, cut, writes, last addr, line_err, done
    vecs[0]  = '{0, 0, 6, -1, 0, 48, 47, 0, 1, "full"};
    vecs[1]  = '{0, 1, 6, -1, 0, 12, 11, 0, 1, "decimated"};
    vecs[2]  = '{1, 0, 6, -1, 0,  0, -1, 0, 0, "paused"};
    vecs[3]  = '{0, 0, 6,  2, 0, 47, 46, 1, 1, "short line"};
    vecs[4]  = '{0, 0, 7, -1, 0, 48, 47, 1, 1, "extra line"};
    vecs[5]  = '{0, 0, 7,  3, 0, 47, 46, 1, 1, "short and extra"};
    vecs[6]  = '{0, 1, 5, -1, 0, 12, 11, 0, 1, "decimated 5 lines"};
    vecs[7]  = '{0, 0, 4, -1, 1, 26, 25, 1, 1, "vsync mid line"};
    vecs[8]  = '{1, 1, 6, -1, 0,  0, -1, 1, 0, "paused keeps err"};
    vecs[9]  = '{0, 0, 6, -1, 0, 48, 47, 0, 1, "full again"};
    vecs[10] = '{0, 1, 7, -1, 0, 12, 11, 1, 1, "decimated extra"};

    rst      = 1'b1;
    vsync    = 1'b0;
    href     = 1'b0;
    din      = 8'h00;
    decimate = 1'b0;
    pause    = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Reset in the middle of a frame: the rest of that frame is discarded.
    start_frame(1'b0, 1'b0);
    drive_line(2 * W, -1);
    drive_line(2 * W, -1);
    check_frame("pre-reset");
    rst = 1'b1;
    cap = 1'b0;
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) tick();
    chk_reset("mid-frame reset");
    rst = 1'b0;
    snap();
    for (int l = 0; l < 4; l++) drive_line(2 * W, -1);
    end_frame();
    check_frame("discarded frame");

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i].pause, vecs[i].dec, vecs[i].nlines, vecs[i].short_line, vecs[i].cut);
      check_frame(vecs[i].name);
      for (int g = 0; g < 2; g++) begin
        na   = act_q[g].size() - a_base[g];
        last = (na > 0) ? act_q[g][act_q[g].size() - 1].addr : -1;
        chk($sformatf("%s dut%0d table writes", vecs[i].name, g), na, vecs[i].exp_writes);
        chk($sformatf("%s dut%0d table last addr", vecs[i].name, g), last, vecs[i].exp_last);
        chk($sformatf("%s dut%0d table line_err", vecs[i].name, g), int'(o_err[g]),
            int'(vecs[i].exp_err));
        chk($sformatf("%s dut%0d table done", vecs[i].name, g), done_cnt[g] - d_base[g],
            vecs[i].exp_done);
      end
    end

    // Randomized frames: line counts, line lengths, decimation and pause.
    for (int f = 0; f < 20; f++) begin
      start_frame(($urandom_range(0, 7) == 0), 1'($urandom));
      nl = $urandom_range(H - 1, H + 1);
      for (int l = 0; l < nl; l++) begin
        nb = ($urandom_range(0, 3) == 0) ? (2 * W - 3 + $urandom_range(0, 6)) : 2 * W;
        drive_line(nb, -1);
      end
      end_frame();
      check_frame($sformatf("random frame %0d", f));
    end

    // Bring the frame counter to 255 with empty frames, then cut a line.
    while (exp_cnt != 255) begin
      start_frame(1'b0, 1'b0);
      end_frame();
    end
    check_frame("count to 255");
    run_frame(1'b0, 1'b0, 2, -1, 1'b1);
    repeat (3) tick();
    check_frame("wrap with cut line");
    for (int g = 0; g < 2; g++)
      chk($sformatf("wrap dut%0d frame_cnt zero", g), int'(o_cnt[g]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
